// File: rtl/conv2_pool_pkg.sv
// conv2_pool_pkg: shared sizes and FSM encoding for the conv2 pooling stage.
// CONV2_POOL_AVG_EN (see pool_lane) switches max pooling to average pooling.
package conv2_pool_pkg;
  localparam int DATA_W    = 8;
  localparam int CH        = 16;
  localparam int ROW_LEN   = 30;
  localparam int OUT_DEPTH = 630;
  localparam int ADDR_W    = 10;
  localparam int COL_W     = $clog2(ROW_LEN + 1);

  localparam logic [COL_W-1:0] ROW_LAST =
    COL_W'(ROW_LEN - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A =
    ADDR_W'(OUT_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;
endpackage

// File: rtl/pool_lane.sv
// pool_lane: one signed channel, max of two (or average with
// CONV2_POOL_AVG_EN, rounding toward -inf).
module pool_lane
  import conv2_pool_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
`ifdef CONV2_POOL_AVG_EN
  logic signed [DATA_W:0] sum;

  assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign y   = DATA_W'(sum >>> 1);
`else
  assign y = ($signed(a) > $signed(b)) ? a : b;
`endif
endmodule

// File: rtl/conv2_maxpool.sv
// conv2_maxpool: 1x2 row pooling of conv2 result vectors into pool RAM.
// CONV2_POOL_AVG_EN selects average pooling instead of max.
module conv2_maxpool
  import conv2_pool_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W*CH-1:0] conv2_output,
  input  logic                 conv_end2,
  input  logic                 conv2_end,
  output logic                 pool_we,
  output logic [ADDR_W-1:0]    pool_addr,
  output logic [DATA_W*CH-1:0] pool_data,
  output logic                 pool_end,
  output logic                 pool_ovf
);
  localparam int VW = DATA_W * CH;

  logic [1:0]       state_q, state_d;
  logic             ce2_q, ce2_d;
  logic             pend_q, pend_d;
  logic [VW-1:0]    pend_data_q, pend_data_d;
  logic [VW-1:0]    hold_q, hold_d;
  logic [VW-1:0]    data_q, data_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic             end_q, end_d;
  logic             ovf_q, ovf_d;

  logic             ev;
  logic             take;
  logic [VW-1:0]    smp;
  logic [VW-1:0]    lane_y;

  assign ev   = conv_end2 & ~ce2_q;
  assign take = ev | pend_q;
  assign smp  = pend_q ? pend_data_q : conv2_output;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane u_lane (
      .a (hold_q[k*DATA_W +: DATA_W]),
      .b (smp[k*DATA_W +: DATA_W]),
      .y (lane_y[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    ce2_d       = conv_end2;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    hold_d      = hold_q;
    data_d      = data_q;
    col_d       = col_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    end_d       = end_q;
    ovf_d       = ovf_q;
    if (we_q)
      addr_d = addr_q + ADDR_W'(1);
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (take) begin
          // a pending sample is used first; a fresh edge refills the slot
          if (pend_q) begin
            pend_d      = ev;
            pend_data_d = conv2_output;
          end
          if (col_q == ROW_LAST) begin
            col_d   = '0;
            data_d  = smp;
            state_d = S_WRITE;
          end else begin
            col_d   = col_q + COL_W'(1);
            hold_d  = smp;
            state_d = S_HOLD;
          end
        end else if (conv2_end) begin
          end_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      (state_q == S_HOLD): begin
        if (take) begin
          if (pend_q) begin
            pend_d      = ev;
            pend_data_d = conv2_output;
          end
          data_d  = lane_y;
          col_d   = (col_q == ROW_LAST) ? '0
                  : col_q + COL_W'(1);
          state_d = S_WRITE;
        end else if (conv2_end) begin
          data_d  = hold_q;
          col_d   = '0;
          state_d = S_WRITE;
        end
      end
      (state_q == S_WRITE): begin
        if (ev && !pend_q) begin
          pend_d      = 1'b1;
          pend_data_d = conv2_output;
        end
        if (addr_q == DEPTH_A)
          ovf_d = 1'b1;
        else
          we_d = 1'b1;
        state_d = S_IDLE;
      end
      (state_q == S_FLUSH): ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ce2_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      hold_q      <= '0;
      data_q      <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      end_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ce2_q       <= ce2_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      end_q       <= end_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pool_we   = we_q;
  assign pool_addr = addr_q;
  assign pool_data = data_q;
  assign pool_end  = end_q;
  assign pool_ovf  = ovf_q;
endmodule

// File: tb/tb_conv2_maxpool.sv
// tb_conv2_maxpool: directed stimulus against a row-pairing
// reference model, plus literal pins for key results.
module tb_conv2_maxpool;
  localparam int DEPTH = 630;
  localparam int RL    = 30;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] conv2_output;
  logic         conv_end2;
  logic         conv2_end;
  logic         pool_we;
  logic [9:0]   pool_addr;
  logic [127:0] pool_data;
  logic         pool_end;
  logic         pool_ovf;

  always #5 clk = ~clk;

  conv2_maxpool dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .conv2_output (conv2_output),
    .conv_end2    (conv_end2),
    .conv2_end    (conv2_end),
    .pool_we      (pool_we),
    .pool_addr    (pool_addr),
    .pool_data    (pool_data),
    .pool_end     (pool_end),
    .pool_ovf     (pool_ovf)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [9:0]   a;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          ce;
  logic [127:0] wr_log [0:1023];
  int           wr_count;
  int           n_chk;
  int           n_pass;

  int           m_pos;
  int           m_wr;
  bit           m_done;
  logic [127:0] m_held;

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [127:0] pool2(input logic [127:0] x,
                                         input logic [127:0] y);
    logic [127:0]       r;
    logic signed [7:0]  p, q;
    logic signed [8:0]  s;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      p = x[8*k +: 8];
      q = y[8*k +: 8];
      s = {p[7], p} + {q[7], q};
`ifdef CONV2_POOL_AVG_EN
      r[8*k +: 8] = 8'(s >>> 1);
`else
      r[8*k +: 8] = (p > q) ? p : q;
`endif
    end
    return r;
  endfunction

  task automatic m_expect(input logic [127:0] v);
    wr_t e;
    if (m_wr < DEPTH) begin
      e.d = v;
      e.a = 10'(m_wr);
      exp_q.push_back(e);
      m_wr++;
    end
  endtask

  task automatic m_sample(input logic [127:0] v);
    if (m_done) return;
    if (m_pos % 2 == 0) begin
      if (m_pos == RL - 1) m_expect(v);
      else m_held = v;
    end else begin
      m_expect(pool2(m_held, v));
    end
    m_pos = (m_pos + 1) % RL;
  endtask

  task automatic m_flush();
    if (!m_done && m_pos % 2 == 1) m_expect(m_held);
    m_done = 1'b1;
  endtask

  task automatic m_clear();
    exp_q.delete();
    m_pos    = 0;
    m_wr     = 0;
    m_done   = 1'b0;
    wr_count = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && pool_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %0d expected no write",
                 pool_addr);
      end else begin
        ce = exp_q.pop_front();
        check("wr_data", pool_data, ce.d);
        check("wr_addr", {118'b0, pool_addr}, {118'b0, ce.a});
      end
      if (wr_count < 1024) wr_log[wr_count] = pool_data;
      wr_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] v);
    conv2_output = v;
    conv_end2    = 1'b1;
    m_sample(v);
    tick();
    conv_end2 = 1'b0;
    tick();
  endtask

  task automatic wait_wr(input int n, input string nm);
    for (int i = 0; i < 40 && wr_count < n; i++) tick();
    check(nm, 128'(wr_count), 128'(n));
  endtask

  task automatic drained(input string nm);
    check(nm, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    conv_end2    = 1'b0;
    conv2_end    = 1'b0;
    conv2_output = '0;
    tick();
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_we"},   128'(pool_we),   128'd0);
    check({nm, "_addr"}, 128'(pool_addr), 128'd0);
    check({nm, "_data"}, pool_data,       128'd0);
    check({nm, "_end"},  128'(pool_end),  128'd0);
    check({nm, "_ovf"},  128'(pool_ovf),  128'd0);
  endtask

  logic [127:0] v;

  initial begin
    n_chk = 0;
    n_pass = 0;
    m_clear();
    rst_n = 1'b0;
    conv_end2 = 1'b0;
    conv2_end = 1'b0;
    conv2_output = '0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    m_clear();

    // ch0 10 then 25
    send(128'd10);
    send(128'd25);
    check("latency_we", 128'(pool_we), 128'd1);
    wait_wr(1, "t1_count");
`ifdef CONV2_POOL_AVG_EN
    check("t1_lit", 128'(wr_log[0][7:0]), 128'd17);
`else
    check("t1_lit", 128'(wr_log[0][7:0]), 128'd25);
`endif
    drained("t1_drain");

    // ch3 -5 then -9
    do_reset();
    send(128'h00_00_00_00_FB_00_00_00);
    send(128'h00_00_00_00_F7_00_00_00);
    wait_wr(1, "t2_count");
`ifdef CONV2_POOL_AVG_EN
    check("t2_lit", 128'(wr_log[0][31:24]), 128'hF9);
`else
    check("t2_lit", 128'(wr_log[0][31:24]), 128'hFB);
`endif
    drained("t2_drain");

    // 60 ramp samples, two rows
    do_reset();
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(i * 3 + k);
      send(v);
    end
    wait_wr(30, "t3_count");
`ifdef CONV2_POOL_AVG_EN
    check("t3_w15", 128'(wr_log[15][7:0]), 128'd91);
`else
    check("t3_w15", 128'(wr_log[15][7:0]), 128'd93);
`endif
    check("t3_addr", 128'(pool_addr), 128'd30);
    drained("t3_drain");

    // 3 samples then layer end
    do_reset();
    send({16{8'h11}});
    send({16{8'h22}});
    send({16{8'h33}});
    conv2_end = 1'b1;
    m_flush();
    for (int i = 0; i < 20 && wr_count < 2; i++) begin
      @(negedge clk);
      #1;
    end
    check("t4_count", 128'(wr_count), 128'd2);
    check("t4_end_lo", 128'(pool_end), 128'd0);
    @(negedge clk);
    #1;
    check("t4_end_hi", 128'(pool_end), 128'd1);
    check("t4_lone", wr_log[1], {16{8'h33}});
    send({16{8'h44}});
    send({16{8'h55}});
    tick();
    tick();
    check("t4_ignored", 128'(wr_count), 128'd2);
    check("t4_end_sticky", 128'(pool_end), 128'd1);
    drained("t4_drain");

    // fill the RAM then overflow
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++)
      send({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_wr(DEPTH, "t5_count");
    check("t5_ovf_lo", 128'(pool_ovf), 128'd0);
    check("t5_addr_full", 128'(pool_addr), 128'd630);
    send({4{$urandom()}});
    send({4{$urandom()}});
    for (int i = 0; i < 6; i++) tick();
    check("t5_suppressed", 128'(wr_count), 128'(DEPTH));
    check("t5_ovf_hi", 128'(pool_ovf), 128'd1);
    check("t5_addr_hold", 128'(pool_addr), 128'd630);
    drained("t5_drain");

    // reset while holding a sample
    send({16{8'h7F}});
    rst_n = 1'b0;
    tick();
    check_zero("t6_rst");
    rst_n = 1'b1;
    m_clear();
    send({16{8'h05}});
    send({16{8'h07}});
    wait_wr(1, "t6_count");
`ifdef CONV2_POOL_AVG_EN
    check("t6_lit", wr_log[0], {16{8'h06}});
`else
    check("t6_lit", wr_log[0], {16{8'h07}});
`endif
    drained("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
